// File: rtl/cmd_flash_decoder.sv
// cmd_flash_decoder: parses 'R'/'W' plus hex address bytes from the UART,
// then issues one gated flash start, a capture window and a quiet gap.
module cmd_flash_decoder #(
   parameter int ADDR_DIGITS    = 2,
   parameter int HOLD_CYCLES    = 500,
   parameter int GAP_CYCLES     = 500,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_byte,
   input  logic                     flash_busy,
   output logic                     start_read,
   output logic                     start_write,
   output logic [4*ADDR_DIGITS-1:0] addr,
   output logic                     write_enable,
   output logic                     busy,
   output logic                     cmd_error,
   output logic                     overrun
);

   localparam int AW = 4 * ADDR_DIGITS;
   localparam int HG = (HOLD_CYCLES > GAP_CYCLES) ?
                       HOLD_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(HG + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(ADDR_DIGITS + 1);
   localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GL);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] DIG_LAST  = DW'(ADDR_DIGITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]    state;
   logic          is_write;
   logic [AW-1:0] shreg;
   logic [DW-1:0] dcnt;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] hcnt;
   logic          hex_ok;
   logic [3:0]    nib;
   logic          is_op;

   always_comb begin
      hex_ok = 1'b1;
      nib    = rx_byte[3:0];
      unique case (1'b1)
         (rx_byte >= 8'h30 && rx_byte <= 8'h39):
            nib = rx_byte[3:0];
         (rx_byte >= 8'h41 && rx_byte <= 8'h46),
         (rx_byte >= 8'h61 && rx_byte <= 8'h66):
            nib = rx_byte[3:0] + 4'd9;
         default:
            hex_ok = 1'b0;
      endcase
   end

   assign is_op = (rx_byte == 8'h52) || (rx_byte == 8'h57);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state        <= S_IDLE;
         is_write     <= 1'b0;
         shreg        <= '0;
         dcnt         <= '0;
         tcnt         <= '0;
         hcnt         <= '0;
         addr         <= '0;
         start_read   <= 1'b0;
         start_write  <= 1'b0;
         write_enable <= 1'b0;
         busy         <= 1'b0;
         cmd_error    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         start_read  <= 1'b0;
         start_write <= 1'b0;
         cmd_error   <= 1'b0;
         overrun     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rx_valid && is_op) begin
                  is_write <= (rx_byte == 8'h57);
                  shreg    <= '0;
                  dcnt     <= '0;
                  tcnt     <= '0;
                  busy     <= 1'b1;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  tcnt <= '0;
                  if (hex_ok) begin
                     // upper nibbles fall off the top of the register
                     shreg <= AW'({shreg, nib});
                     if (dcnt == DIG_LAST) begin
                        state <= S_ISSUE;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end else begin
                     cmd_error <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (tcnt == TO_LAST) begin
                  cmd_error <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_ISSUE: begin
               overrun <= rx_valid;
               if (!flash_busy) begin
                  addr         <= shreg;
                  start_read   <= !is_write;
                  start_write  <= is_write;
                  write_enable <= 1'b1;
                  hcnt         <= '0;
                  state        <= S_HOLD;
               end
            end
            S_HOLD: begin
               overrun <= rx_valid;
               if (hcnt == HOLD_LAST) begin
                  write_enable <= 1'b0;
                  hcnt         <= '0;
                  if (GAP_CYCLES == 0) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  hcnt <= hcnt + CW'(1);
               end
            end
            S_GAP: begin
               overrun <= rx_valid;
               if (hcnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  hcnt <= hcnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_flash_decoder.sv
// Bench for cmd_flash_decoder: randomized UART bytes, a timeline model
// predicting pulses and windows, and a monitor comparing each cycle.
module tb_cmd_flash_decoder;

   localparam int D   = 4;
   localparam int H   = 7;
   localparam int G   = 5;
   localparam int TMO = 16;

   typedef struct {
      int        c;
      bit        w;
      bit [15:0] a;
   } start_t;

   typedef struct {
      int s;
      int e;
   } win_t;

   typedef struct {
      int        c;
      bit [15:0] v;
   } ad_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        flash_busy = 1'b0;
   logic        start_read;
   logic        start_write;
   logic [15:0] addr;
   logic        write_enable;
   logic        busy;
   logic        cmd_error;
   logic        overrun;

   cmd_flash_decoder #(
      .ADDR_DIGITS    (D),
      .HOLD_CYCLES    (H),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .flash_busy   (flash_busy),
      .start_read   (start_read),
      .start_write  (start_write),
      .addr         (addr),
      .write_enable (write_enable),
      .busy         (busy),
      .cmd_error    (cmd_error),
      .overrun      (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_on  = 1'b0;

   start_t start_q[$];
   int     err_q[$];
   int     ovr_q[$];
   win_t   we_q[$];
   win_t   bsy_q[$];
   ad_t    ad_q[$];

   // model of the command timeline, in edge numbers
   bit        parsing = 0;
   bit        pending = 0;
   bit        open_w  = 0;
   int        m_o     = 0;
   int        m_last  = 0;
   int        m_b     = 0;
   int        m_nd    = 0;
   bit        m_w     = 0;
   bit [15:0] m_val   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got %0h, want %0h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic miss(input string nm, input int c);
      n_tests++;
      n_fail++;
      $display("FAIL %s_missed: got no pulse, want one at %0d",
               nm, c);
   endtask

   function automatic int hexval(input logic [7:0] b);
      if (b >= "0" && b <= "9") return int'(b) - int'("0");
      if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
      if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
      return -1;
   endfunction

   function automatic bit rfb();
      return $urandom_range(0, 2) == 0;
   endfunction

   function automatic bit idle_next();
      return !parsing && !pending && (cyc + 1 > m_b);
   endfunction

   task automatic do_reset(input int n);
      parsing = 0;
      pending = 0;
      open_w  = 0;
      m_b     = 0;
      foreach (we_q[i]) if (we_q[i].e > n) we_q[i].e = n;
      foreach (bsy_q[i]) if (bsy_q[i].e > n) bsy_q[i].e = n;
      start_q = start_q.find(x) with (x.c < n);
      err_q   = err_q.find(x) with (x < n);
      ovr_q   = ovr_q.find(x) with (x < n);
      ad_q    = ad_q.find(x) with (x.c < n);
      ad_q.push_back('{n, 16'h0});
   endtask

   task automatic close_err(input int n);
      parsing = 0;
      open_w  = 0;
      err_q.push_back(n);
      bsy_q.push_back('{m_o, n});
   endtask

   task automatic step(input logic v, input logic [7:0] b,
                       input logic fb, input logic rst);
      int n;
      int hv;
      @(negedge sys_clk);
      sys_rst_n  = rst;
      rx_valid   = v;
      rx_byte    = b;
      flash_busy = fb;
      n = cyc + 1;
      if (!rst) begin
         do_reset(n);
         return;
      end
      if (pending || n <= m_b) begin
         if (v) ovr_q.push_back(n);
         if (pending && !fb) begin
            pending = 0;
            open_w  = 0;
            m_b     = n + H + G;
            start_q.push_back('{n, m_w, m_val});
            we_q.push_back('{n, n + H});
            bsy_q.push_back('{m_o, m_b});
            ad_q.push_back('{n, m_val});
         end
      end else if (parsing) begin
         if (v) begin
            m_last = n;
            hv = hexval(b);
            if (hv >= 0) begin
               m_val = (m_val << 4) | 16'(hv);
               m_nd++;
               if (m_nd == D) begin
                  parsing = 0;
                  pending = 1;
               end
            end else begin
               close_err(n);
            end
         end else if (n - m_last == TMO) begin
            close_err(n);
         end
      end else if (v && (b == "R" || b == "W")) begin
         parsing = 1;
         open_w  = 1;
         m_o     = n;
         m_last  = n;
         m_val   = 0;
         m_nd    = 0;
         m_w     = (b == "W");
      end
   endtask

   task automatic idle(input int k);
      repeat (k) step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (!idle_next() && g < 1000) begin
         step(1'b0, 8'h00, 1'b0, 1'b1);
         g++;
      end
   endtask

   task automatic rand_cmd();
      string      hx = "0123456789abcdefABCDEF";
      logic [7:0] b;
      int         gp;
      int         g;
      repeat ($urandom_range(0, 2)) begin
         do b = 8'($urandom_range(0, 255));
         while (b == "R" || b == "W");
         step(1'b1, b, rfb(), 1'b1);
      end
      b = ($urandom_range(0, 1) == 0) ? "R" : "W";
      step(1'b1, b, rfb(), 1'b1);
      for (int d = 0; d < D; d++) begin
         gp = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) gp = TMO + 1;
         for (int k = 0; k < gp; k++) begin
            if (parsing) step(1'b0, 8'h00, rfb(), 1'b1);
         end
         if (!parsing) break;
         if ($urandom_range(0, 11) == 0) begin
            do b = 8'($urandom_range(0, 255));
            while (hexval(b) >= 0);
         end else begin
            b = hx[$urandom_range(0, 21)];
         end
         step(1'b1, b, rfb(), 1'b1);
         if (!parsing) break;
      end
      g = 0;
      while (!idle_next() && g < 500) begin
         b = 8'($urandom_range(0, 255));
         step($urandom_range(0, 5) == 0, b, rfb(), 1'b1);
         g++;
      end
   endtask

   always @(negedge sys_clk) begin
      int     c;
      bit     e_we;
      bit     e_bsy;
      bit [15:0] e_ad;
      start_t st;
      if (mon_on) begin
         c = cyc;
         e_we = 0;
         foreach (we_q[i])
            if (c >= we_q[i].s && c < we_q[i].e) e_we = 1;
         e_bsy = open_w && (c >= m_o);
         foreach (bsy_q[i])
            if (c >= bsy_q[i].s && c < bsy_q[i].e) e_bsy = 1;
         while (ad_q.size() > 1 && ad_q[1].c <= c)
            void'(ad_q.pop_front());
         e_ad = (ad_q.size() > 0 && ad_q[0].c <= c) ?
                ad_q[0].v : 16'h0;
         chk("write_enable", int'(write_enable), int'(e_we));
         chk("busy", int'(busy), int'(e_bsy));
         chk("addr", int'(addr), int'(e_ad));
         chk("start_excl", int'(start_read & start_write), 0);
         while (start_q.size() > 0 && start_q[0].c < c)
            miss("start", start_q.pop_front().c);
         while (err_q.size() > 0 && err_q[0] < c)
            miss("cmd_error", err_q.pop_front());
         while (ovr_q.size() > 0 && ovr_q[0] < c)
            miss("overrun", ovr_q.pop_front());
         if (start_read || start_write) begin
            if (start_q.size() == 0) begin
               chk("start_unexpected", 1, 0);
            end else begin
               st = start_q.pop_front();
               chk("start_cyc", c, st.c);
               chk("start_write", int'(start_write), int'(st.w));
               chk("start_addr", int'(addr), int'(st.a));
            end
         end
         if (cmd_error) begin
            if (err_q.size() == 0) chk("err_unexpected", 1, 0);
            else chk("err_cyc", c, err_q.pop_front());
         end
         if (overrun) begin
            if (ovr_q.size() == 0) chk("ovr_unexpected", 1, 0);
            else chk("ovr_cyc", c, ovr_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want end of run");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      mon_on = 1'b1;
      idle(3);

      send("W"); send("b"); send("E"); send("0"); send("f");
      wait_idle();

      send("R"); send("G");
      idle(3);
      send("R"); send("0"); send("1"); send("2"); send("3");
      wait_idle();

      send("R");
      idle(TMO + 4);
      send("5");
      idle(TMO + 4);

      send("R"); send("7"); send("7"); send("7");
      step(1'b1, "7", 1'b1, 1'b1);
      for (int k = 0; k < 40; k++)
         step(k == 12 || k == 39, "W", 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      idle(2);
      send("R");
      wait_idle();

      send("W"); send("a"); send("b"); send("c"); send("d");
      idle(3);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      idle(H + G + 4);

      send("R"); send("4"); send("2"); send("4"); send("2");
      while (cyc + 1 < m_b) idle(1);
      send("R");
      send("1"); send("2"); send("3"); send("4");
      idle(TMO + 4);

      for (int i = 0; i < 150; i++) rand_cmd();

      idle(30);
      chk("start_q_left", start_q.size(), 0);
      chk("err_q_left", err_q.size(), 0);
      chk("ovr_q_left", ovr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
